// File: rtl/probe_force_target.sv
// Forceable DUT-side target: free-running counter r, registered follower out, and a
// valid/ready command port that forces, releases, deposits into or reads either one.
module probe_force_target #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] INIT  = 16'd0,
   parameter logic [WIDTH-1:0] STEP  = 16'd1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             cmd_sel,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [1:0]       rsp_forced,
   output logic [WIDTH-1:0] r_probe,
   output logic [WIDTH-1:0] out
);

   localparam logic [1:0] OP_READ    = 2'd0;
   localparam logic [1:0] OP_FORCE   = 2'd1;
   localparam logic [1:0] OP_RELEASE = 2'd2;
   localparam logic [1:0] OP_DEPOSIT = 2'd3;

   logic [WIDTH-1:0] r_q_r,      out_q_r;
   logic [WIDTH-1:0] r_fval_r,   out_fval_r;
   logic             r_forced_r, out_forced_r;
   logic             rsp_valid_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic [1:0]       rsp_forced_r;

   logic             accept_s;
   logic [WIDTH-1:0] r_vis_s;
   logic [WIDTH-1:0] r_q_nxt_s,      out_q_nxt_s;
   logic [WIDTH-1:0] r_fval_nxt_s,   out_fval_nxt_s;
   logic             r_forced_nxt_s, out_forced_nxt_s;
   logic [WIDTH-1:0] rsp_data_nxt_s;

   assign cmd_ready  = !rsp_valid_r || rsp_ready;
   assign accept_s   = cmd_valid && cmd_ready;
   assign r_vis_s    = r_forced_r ? r_fval_r : r_q_r;
   assign r_probe    = r_vis_s;
   assign out        = out_forced_r ? out_fval_r : out_q_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_data   = rsp_data_r;
   assign rsp_forced = rsp_forced_r;

   // Next-state datapath with the accepted command applied on top of it
   always_comb begin
      r_q_nxt_s        = r_forced_r ? r_fval_r : r_vis_s + STEP;
      out_q_nxt_s      = r_vis_s;
      r_fval_nxt_s     = r_fval_r;
      out_fval_nxt_s   = out_fval_r;
      r_forced_nxt_s   = r_forced_r;
      out_forced_nxt_s = out_forced_r;
      if (accept_s) begin
         case (cmd_op)
            OP_FORCE: begin
               if (cmd_sel) begin
                  out_forced_nxt_s = 1'b1;
                  out_fval_nxt_s   = cmd_data;
               end else begin
                  r_forced_nxt_s = 1'b1;
                  r_fval_nxt_s   = cmd_data;
               end
            end
            OP_RELEASE: begin
               if (cmd_sel) begin
                  out_forced_nxt_s = 1'b0;
               end else begin
                  r_forced_nxt_s = 1'b0;
               end
            end
            OP_DEPOSIT: begin
               if (cmd_sel) begin
                  out_q_nxt_s = cmd_data;
               end else begin
                  r_q_nxt_s = cmd_data;
               end
            end
            OP_READ: begin
               r_forced_nxt_s = r_forced_r;
            end
            default: begin
               r_forced_nxt_s = r_forced_r;
            end
         endcase
      end else begin
         r_forced_nxt_s = r_forced_r;
      end
      // Response shows the visible value as it will stand after this edge
      if (cmd_sel) begin
         rsp_data_nxt_s = out_forced_nxt_s ? out_fval_nxt_s : out_q_nxt_s;
      end else begin
         rsp_data_nxt_s = r_forced_nxt_s ? r_fval_nxt_s : r_q_nxt_s;
      end
   end

   // State, force bookkeeping and single-entry response register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q_r        <= INIT;
         out_q_r      <= INIT;
         r_fval_r     <= {WIDTH{1'b0}};
         out_fval_r   <= {WIDTH{1'b0}};
         r_forced_r   <= 1'b0;
         out_forced_r <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_data_r   <= {WIDTH{1'b0}};
         rsp_forced_r <= 2'b00;
      end else begin
         r_q_r        <= r_q_nxt_s;
         out_q_r      <= out_q_nxt_s;
         r_fval_r     <= r_fval_nxt_s;
         out_fval_r   <= out_fval_nxt_s;
         r_forced_r   <= r_forced_nxt_s;
         out_forced_r <= out_forced_nxt_s;
         if (accept_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_data_r   <= rsp_data_nxt_s;
            rsp_forced_r <= {out_forced_nxt_s, r_forced_nxt_s};
         end else if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
         end else begin
            rsp_valid_r  <= rsp_valid_r;
         end
      end
   end

endmodule
